// File: rtl/pixel_readout.sv
// Row-sequential pixel array readout: one-hot row select, row capture, valid/ready pixel stream.
// Define PIXEL_READOUT_PREFETCH_EN to latch the next row in the background while the current row streams.
module pixel_readout #(
  parameter int WIDTH      = 3,
  parameter int HEIGHT     = 3,
  parameter int PIXEL_BITS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [HEIGHT-1:0]             read_row,
  input  logic [WIDTH*PIXEL_BITS-1:0]   data_in,
  output logic [PIXEL_BITS-1:0]         pixel_out,
  output logic                          pixel_valid,
  input  logic                          pixel_ready,
  output logic                          pixel_last,
  output logic [$clog2(HEIGHT)-1:0]     row_idx,
  output logic [$clog2(WIDTH)-1:0]      col_idx
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0]     COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0]     ROW_MAX = RW'(HEIGHT - 1);
  localparam logic [HEIGHT-1:0] SEL0    = HEIGHT'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                  state;
  logic [WIDTH*PIXEL_BITS-1:0] row_buf;
  logic                        handshake;
  logic [RW-1:0]               row_next;
  logic [CW-1:0]               col_next;

  assign handshake = pixel_valid && pixel_ready;
  assign row_next  = row_idx + RW'(1);
  assign col_next  = col_idx + CW'(1);

`ifdef PIXEL_READOUT_PREFETCH_EN
  // bg_phase: 0 none, 1 settle cycle, 2 latch cycle, 3 next row held in next_buf
  logic [WIDTH*PIXEL_BITS-1:0] next_buf;
  logic [1:0]                  bg_phase;
  logic [WIDTH*PIXEL_BITS-1:0] next_src;

  // A row switch landing on the background latch cycle forwards the bus directly.
  assign next_src = (bg_phase == 2'd3) ? next_buf : data_in;
`endif

  function automatic logic [PIXEL_BITS-1:0] pick(input logic [WIDTH*PIXEL_BITS-1:0] bus,
                                                 input logic [CW-1:0] col);
    pick = bus[col*PIXEL_BITS +: PIXEL_BITS];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      read_row    <= '0;
      pixel_valid <= 1'b0;
      pixel_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pixel_out   <= '0;
      row_idx     <= '0;
      col_idx     <= '0;
      row_buf     <= '0;
`ifdef PIXEL_READOUT_PREFETCH_EN
      next_buf    <= '0;
      bg_phase    <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            row_idx  <= '0;
            col_idx  <= '0;
            read_row <= SEL0;
            busy     <= 1'b1;
            state    <= S_SELECT;
          end
        end
        S_SELECT: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          row_buf     <= data_in;
          read_row    <= '0;
          col_idx     <= '0;
          pixel_out   <= pick(data_in, CW'(0));
          pixel_valid <= 1'b1;
          pixel_last  <= (row_idx == ROW_MAX) && (COL_MAX == CW'(0));
          state       <= S_STREAM;
`ifdef PIXEL_READOUT_PREFETCH_EN
          if (row_idx != ROW_MAX) begin
            read_row <= SEL0 << row_next;
            bg_phase <= 2'd1;
          end
`endif
        end
        S_STREAM: begin
`ifdef PIXEL_READOUT_PREFETCH_EN
          if (bg_phase == 2'd1) begin
            bg_phase <= 2'd2;
          end else if (bg_phase == 2'd2) begin
            next_buf <= data_in;
            read_row <= '0;
            bg_phase <= 2'd3;
          end
`endif
          if (handshake) begin
            if (col_idx != COL_MAX) begin
              col_idx    <= col_next;
              pixel_out  <= pick(row_buf, col_next);
              pixel_last <= (row_idx == ROW_MAX) && (col_next == COL_MAX);
            end else if (row_idx != ROW_MAX) begin
              row_idx <= row_next;
`ifdef PIXEL_READOUT_PREFETCH_EN
              if (bg_phase[1]) begin
                col_idx    <= '0;
                row_buf    <= next_src;
                pixel_out  <= pick(next_src, CW'(0));
                pixel_last <= (row_next == ROW_MAX) && (COL_MAX == CW'(0));
                read_row   <= '0;
                bg_phase   <= 2'd0;
                if (row_next != ROW_MAX) begin
                  read_row <= SEL0 << (row_next + RW'(1));
                  bg_phase <= 2'd1;
                end
              end else begin
                // Very short rows: the next row has only settled one cycle, finish it in LATCH.
                pixel_valid <= 1'b0;
                pixel_last  <= 1'b0;
                bg_phase    <= 2'd0;
                state       <= S_LATCH;
              end
`else
              read_row    <= SEL0 << row_next;
              pixel_valid <= 1'b0;
              pixel_last  <= 1'b0;
              state       <= S_SELECT;
`endif
            end else begin
              pixel_valid <= 1'b0;
              pixel_last  <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          read_row    <= '0;
          pixel_valid <= 1'b0;
          pixel_last  <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: scoreboard of expected pixels against the stream handshakes.
// Honors PIXEL_READOUT_PREFETCH_EN for the expected frame time.
module tb_pixel_readout;

  localparam int W  = 3;
  localparam int H  = 3;
  localparam int P  = 8;
  localparam int RW = 2;
  localparam int CW = 2;
`ifdef PIXEL_READOUT_PREFETCH_EN
  localparam int EXP_CYCLES = 2 + H * W;
`else
  localparam int EXP_CYCLES = H * (W + 2);
`endif

  typedef struct packed {
    logic [P-1:0]  pix;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           start;
  logic           busy;
  logic           done;
  logic [H-1:0]   read_row;
  logic [W*P-1:0] data_in;
  logic [P-1:0]   pixel_out;
  logic           pixel_valid;
  logic           pixel_ready;
  logic           pixel_last;
  logic [RW-1:0]  row_idx;
  logic [CW-1:0]  col_idx;
  logic           float_x;

  int   checks;
  int   failures;
  exp_t exp_q[$];

  pixel_readout #(.WIDTH(W), .HEIGHT(H), .PIXEL_BITS(P)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .read_row(read_row), .data_in(data_in), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_last(pixel_last),
    .row_idx(row_idx), .col_idx(col_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Undriven bus alternates between X and Z so stale or floating data is visible.
  initial float_x = 1'b0;
  always @(posedge clk) float_x <= ~float_x;

  function automatic logic [W*P-1:0] bus_word(input logic [H-1:0] sel, input logic fx);
    logic [W*P-1:0] w;
    w = fx ? {(W*P){1'bx}} : {(W*P){1'bz}};
    for (int r = 0; r < H; r++) begin
      if (sel == (H'(1) << r)) begin
        for (int c = 0; c < W; c++) w[c*P +: P] = P'(16 * r + c);
      end
    end
    return w;
  endfunction

  assign data_in = bus_word(read_row, float_x);

  task automatic run_frame(input bit rand_ready, input bit poke_start, output int cycles);
    exp_t         e;
    exp_t         got;
    exp_t         held;
    bit           stalled;
    bit           last_hs;
    bit           poked;
    bit           done_seen;
    logic [H-1:0] rr_prev;
    int           rr_len;
    int           sel_cnt;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.pix  = P'(16 * r + c);
        e.row  = RW'(r);
        e.col  = CW'(c);
        e.last = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
    end
    stalled = 1'b0; last_hs = 1'b0; poked = 1'b0; done_seen = 1'b0;
    rr_prev = '0; rr_len = 0; sel_cnt = 0; cycles = 0; held = '0;
    @(negedge clk);
    start = 1'b1;
    pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cycles < 2000) begin
      start = 1'b0;
      checks++;
      if ($isunknown(pixel_out)) begin
        failures++; $display("FAIL bus_isolation: pixel_out=%h carries X/Z", pixel_out);
      end
      checks++;
      if (!$onehot0(read_row)) begin
        failures++; $display("FAIL read_row_onehot: got %b, need one-hot or zero", read_row);
      end
      if (read_row == rr_prev) begin
        rr_len++;
      end else begin
        if (rr_prev != '0) begin
          checks++;
          if (rr_len != 2) begin
            failures++; $display("FAIL read_row_len: %b held %0d cycles, need 2", rr_prev, rr_len);
          end
        end
        if (read_row != '0) begin
          checks++;
          if (read_row !== (H'(1) << sel_cnt)) begin
            failures++; $display("FAIL read_row_order: got %b, need %b", read_row, H'(1) << sel_cnt);
          end
          sel_cnt++;
        end
        rr_prev = read_row;
        rr_len  = 1;
      end
      if (stalled) begin
        got = {pixel_out, row_idx, col_idx, pixel_last};
        checks++;
        if (!pixel_valid || got !== held) begin
          failures++;
          $display("FAIL stall_hold: valid=%b out=%h, need valid=1 out=%h", pixel_valid, got, held);
        end
      end
      if (done) begin
        done_seen = 1'b1;
        checks++;
        if (!last_hs || busy !== 1'b0 || pixel_valid !== 1'b0 || read_row !== '0) begin
          failures++;
          $display("FAIL done_pulse: last_hs=%b busy=%b valid=%b read_row=%b, need 1 0 0 000",
                   last_hs, busy, pixel_valid, read_row);
        end
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL busy: got %b at cycle %0d, need 1", busy, cycles);
      end
      if (poke_start && !poked && row_idx == RW'(1) && pixel_valid) begin
        start = 1'b1;
        poked = 1'b1;
      end
      pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      last_hs = 1'b0;
      if (pixel_valid && pixel_ready) begin
        got = {pixel_out, row_idx, col_idx, pixel_last};
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL pixel_extra: got %h, need no pixel", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL pixel: got pix=%h row=%0d col=%0d last=%b, need pix=%h row=%0d col=%0d last=%b",
                     got.pix, got.row, got.col, got.last, e.pix, e.row, e.col, e.last);
          end
        end
        last_hs = pixel_last;
      end
      stalled = pixel_valid && !pixel_ready;
      held    = {pixel_out, row_idx, col_idx, pixel_last};
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++; $display("FAIL frame_timeout: no done after %0d cycles, need done", cycles);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL pixels_missing: %0d left, need 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (sel_cnt != H) begin
      failures++; $display("FAIL row_selects: got %0d, need %0d", sel_cnt, H);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || pixel_valid !== 1'b0 || read_row !== '0) begin
        failures++;
        $display("FAIL post_frame_idle: done=%b busy=%b valid=%b read_row=%b, need 0 0 0 000",
                 done, busy, pixel_valid, read_row);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pixel_ready = 1'b0;
    #3;
    checks++;
    if ({read_row, pixel_valid, pixel_last, busy, done, pixel_out, row_idx, col_idx} !== '0) begin
      failures++;
      $display("FAIL reset_state: read_row=%b valid=%b last=%b busy=%b done=%b out=%h row=%0d col=%0d, need all 0",
               read_row, pixel_valid, pixel_last, busy, done, pixel_out, row_idx, col_idx);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b valid=%b, need 0 0", busy, pixel_valid);
    end
  endtask

  task automatic test_full_frame();
    int cyc;
    run_frame(1'b0, 1'b0, cyc);
    checks++;
    if (cyc != EXP_CYCLES) begin
      failures++; $display("FAIL frame_time: got %0d cycles, need %0d", cyc, EXP_CYCLES);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      run_frame(1'b1, 1'b0, cyc);
      checks++;
      if (cyc < EXP_CYCLES) begin
        failures++; $display("FAIL bp_frame_time: got %0d cycles, need >= %0d", cyc, EXP_CYCLES);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    run_frame(1'b0, 1'b1, cyc);
    checks++;
    if (cyc != EXP_CYCLES) begin
      failures++; $display("FAIL busy_start_time: got %0d cycles, need %0d", cyc, EXP_CYCLES);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int cyc;
    @(negedge clk);
    start = 1'b1; pixel_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(row_idx == RW'(1) && (col_idx == CW'(1) || read_row != '0)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100 || read_row == '0) begin
      failures++; $display("FAIL mid_frame_reach: waited %0d read_row=%b, need row 1 with select active", n, read_row);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({read_row, pixel_valid, pixel_last, busy, done, pixel_out, row_idx, col_idx} !== '0) begin
      failures++;
      $display("FAIL mid_reset_state: read_row=%b valid=%b last=%b busy=%b done=%b out=%h row=%0d col=%0d, need all 0",
               read_row, pixel_valid, pixel_last, busy, done, pixel_out, row_idx, col_idx);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++; $display("FAIL mid_reset_done: got %b, need 0", done);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    run_frame(1'b0, 1'b0, cyc);
    checks++;
    if (cyc != EXP_CYCLES) begin
      failures++; $display("FAIL restart_frame_time: got %0d cycles, need %0d", cyc, EXP_CYCLES);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Row-sequential readout controller placed directly downstream of the pixel array. It drives the array's one-hot row-select (`READ`) lines and captures the shared tri-state row data bus into a row buffer. It then serializes the captured row into a pixel stream with a valid/ready handshake, for the image output stage. One `start` pulse reads one full frame, top row first, column 0 first.

## Interface
Parameters:
- `WIDTH`, 3, pixels per row
- `HEIGHT`, 3, rows per frame
- `PIXEL_BITS`, 8, bits per pixel

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  frame request, sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the last pixel handshake of the frame
- `read_row`  out  HEIGHT  one-hot row select to the array; bit r selects row r
- `data_in`  in  WIDTH*PIXEL_BITS  array row bus; column c is at `[c*PIXEL_BITS +: PIXEL_BITS]`
- `pixel_out`  out  PIXEL_BITS  current pixel
- `pixel_valid`  out  1  `pixel_out` is valid
- `pixel_ready`  in  1  downstream accepts the pixel
- `pixel_last`  out  1  high with the final pixel of the frame (row HEIGHT-1, column WIDTH-1)
- `row_idx`  out  clog2(HEIGHT)  row of the current pixel
- `col_idx`  out  clog2(WIDTH)  column of the current pixel

## Operation
- States: IDLE, SELECT, LATCH, STREAM, DONE.
- IDLE:
  - `start`=1 clears the row counter to 0, sets `read_row`=1<<0 and `busy`=1, then goes to SELECT.
- SELECT:
  - One settle cycle for the tri-state bus; `read_row` is held.
  - Goes to LATCH.
- LATCH:
  - `read_row` is still held.
  - At the end of the cycle, the row buffer captures `data_in`, `read_row` goes to 0, the column counter clears to 0, and the state goes to STREAM.
- STREAM:
  - `pixel_out` = buffer[col]; `pixel_valid`=1.
  - On `pixel_valid && pixel_ready`:
    - If col < WIDTH-1: col++.
    - Else, if row < HEIGHT-1: row++, `read_row`=1<<row, go to SELECT.
    - Else: go to DONE.
- DONE:
  - `done`=1 and `busy`=0 for one cycle, then IDLE.
- `start` is ignored whenever the state is not IDLE.
- `read_row` has at most one bit set at any time. It is zero in IDLE, STREAM and DONE.
- `pixel_out`, `row_idx`, `col_idx` and `pixel_last` are stable while `pixel_valid && !pixel_ready`. `pixel_valid` never drops without a handshake.
- Counters never wrap: the row counter is bounded by HEIGHT-1 and the column counter by WIDTH-1.
- Data in `data_in` outside the LATCH cycle is ignored. Z or X values there must not propagate.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state=IDLE; `read_row`=0; `pixel_valid`=0; `pixel_last`=0; `busy`=0; `done`=0.
  - `pixel_out`=0; `row_idx`=0; `col_idx`=0; row buffer=0.
- Reset mid-frame aborts the frame with no `done` pulse. The first `start` after reset is released begins a fresh frame at row 0.
- With `start` accepted at edge E0:
  - `read_row` is high after E0 for exactly 2 cycles.
  - The row is captured at E2.
  - The first `pixel_valid` is high after E2.
- Each row costs 2 overhead cycles (SELECT + LATCH) plus WIDTH handshakes.
- Minimum frame time with `pixel_ready`=1: HEIGHT*(WIDTH+2) cycles, plus 1 cycle of DONE.
- `done` rises the cycle after the `pixel_last` handshake.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `PIXEL_READOUT_PREFETCH_EN` defined:
  - Adds a second row buffer.
  - While row r streams, row r+1 is selected and latched in the background, starting in the first STREAM cycle of row r.
  - When the last column of row r is handshaken, streaming moves straight to row r+1 with no gap. There are no bubble cycles between rows.
  - `read_row` is still one-hot, still held for 2 cycles, and still never asserted during DONE or IDLE.
  - Frame time with `pixel_ready`=1: 2 + HEIGHT*WIDTH cycles.
- Not defined:
  - Single buffer; 2 bubble cycles per row, as described in Operation.

## Test plan
- Full frame:
  - Stimulus: 3x3 array model with pixel value = 16*row+col; `pixel_ready`=1; one `start` pulse.
  - Response: 9 pixels 0x00,0x01,0x02,0x10,…,0x22 in order. `pixel_last` only on 0x22. `done` one cycle later. Total 15 cycles without prefetch, 11 with prefetch.
- Backpressure:
  - Stimulus: `pixel_ready` toggles in a random pattern.
  - Response: no pixel is lost or duplicated. Outputs are held stable while stalled. The pixel sequence is identical to the full-frame case.
- Row select:
  - Stimulus: a monitor on `read_row` for a whole frame.
  - Response: always one-hot or zero. Each row is asserted for exactly 2 cycles, in order 001, 010, 100.
- Start while busy:
  - Stimulus: pulse `start` during row 1 streaming.
  - Response: ignored; a single frame of 9 pixels and a single `done`.
- Reset mid-frame:
  - Stimulus: assert `reset` during row 1 column 1 with `read_row` active.
  - Response: all outputs reach their reset values immediately and no `done` pulse occurs. The next `start` streams from pixel 0x00.
- Bus isolation:
  - Stimulus: drive `data_in` to X/Z outside LATCH cycles.
  - Response: `pixel_out` never carries X.
